// File: rtl/stopwatch_pkg.sv
// Shared constants, field widths and the time-field bundle for the stopwatch.
package stopwatch_pkg;

  localparam int unsigned MS_MAX  = 999;
  localparam int unsigned S_MAX   = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam int unsigned MS_W  = 10;
  localparam int unsigned S_W   = 6;
  localparam int unsigned MIN_W = 6;

  // Widest hour field the shared bundle can carry; HR_BITS must not exceed it.
  localparam int unsigned HR_W_MAX = 8;

  typedef struct packed {
    logic [HR_W_MAX-1:0] hr;
    logic [MIN_W-1:0]    min;
    logic [S_W-1:0]      s;
    logic [MS_W-1:0]     ms;
  } time_fields_t;

  // Value a modulo-(max+1) counter takes after one edge with increment enable inc.
  function automatic int unsigned step_mod(input int unsigned value,
                                           input int unsigned max,
                                           input logic        inc);
    if (!inc) return value;
    return (value == max) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/stopwatch_counter_mod_counter.sv
// Generic modulo counter with synchronous clear and a same-edge carry output.
module mod_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         carry_out
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] r_value;
  logic         w_at_last;

  assign w_at_last = (r_value == LAST);
  assign carry_out = inc & w_at_last;
  assign value     = r_value;

  // Count 0..MOD-1 on inc; clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= w_at_last ? '0 : r_value + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch: prescaler plus cascaded ms/s/min/hr modulo counters with a sticky
// overflow flag. Define STOPWATCH_LAP_EN to add the lap snapshot registers.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 1000,
  parameter int unsigned HR_MOD     = 10,
  parameter int unsigned HR_BITS    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  output logic [MS_W-1:0]    ms,
  output logic [S_W-1:0]     s,
  output logic [MIN_W-1:0]   min,
  output logic [HR_BITS-1:0] hr,
  output logic               running,
  output logic               overflow
`ifdef STOPWATCH_LAP_EN
  ,
  input  logic               lap,
  output logic [MS_W-1:0]    lap_ms,
  output logic [S_W-1:0]     lap_s,
  output logic [MIN_W-1:0]   lap_min,
  output logic [HR_BITS-1:0] lap_hr,
  output logic               lap_valid
`endif
);

  localparam int unsigned PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic             r_running;
  logic             r_overflow;
  logic [PRE_W-1:0] w_unused_prescale;
  logic             w_ms_tick;
  logic             w_ms_carry;
  logic             w_s_carry;
  logic             w_min_carry;
  logic             w_hr_carry;

  assign running  = r_running;
  assign overflow = r_overflow;

  // Run control: clear leaves running alone, stop beats start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_running <= 1'b0;
    end else if (!clear) begin
      if (stop) begin
        r_running <= 1'b0;
      end else if (start) begin
        r_running <= 1'b1;
      end
    end
  end

  // Prescaler only advances while running, so a pause keeps the partial millisecond.
  mod_counter #(.MOD(CLK_PER_MS), .W(PRE_W)) u_pre (
    .clk(clk), .reset(reset), .inc(r_running), .clr(clear),
    .value(w_unused_prescale), .carry_out(w_ms_tick)
  );

  mod_counter #(.MOD(MS_MAX + 1), .W(MS_W)) u_ms (
    .clk(clk), .reset(reset), .inc(w_ms_tick), .clr(clear),
    .value(ms), .carry_out(w_ms_carry)
  );

  mod_counter #(.MOD(S_MAX + 1), .W(S_W)) u_sec (
    .clk(clk), .reset(reset), .inc(w_ms_carry), .clr(clear),
    .value(s), .carry_out(w_s_carry)
  );

  mod_counter #(.MOD(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk(clk), .reset(reset), .inc(w_s_carry), .clr(clear),
    .value(min), .carry_out(w_min_carry)
  );

  mod_counter #(.MOD(HR_MOD), .W(HR_BITS)) u_hr (
    .clk(clk), .reset(reset), .inc(w_min_carry), .clr(clear),
    .value(hr), .carry_out(w_hr_carry)
  );

  // Sticky overflow on a full wrap of every field; only clear or reset drop it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_hr_carry) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [MS_W-1:0]    w_ms_nxt;
  logic [S_W-1:0]     w_s_nxt;
  logic [MIN_W-1:0]   w_min_nxt;
  logic [HR_BITS-1:0] w_hr_nxt;
  time_fields_t       r_lap;
  logic               r_lap_valid;

  // Field values after this edge, so a lap shows what the outputs read next cycle.
  assign w_ms_nxt  = MS_W'(step_mod(32'(ms), MS_MAX, w_ms_tick));
  assign w_s_nxt   = S_W'(step_mod(32'(s), S_MAX, w_ms_carry));
  assign w_min_nxt = MIN_W'(step_mod(32'(min), MIN_MAX, w_s_carry));
  assign w_hr_nxt  = HR_BITS'(step_mod(32'(hr), HR_MOD - 1, w_min_carry));

  // Lap snapshot: clear wipes it, otherwise each lap overwrites the last capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap       <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear) begin
      r_lap       <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap) begin
      r_lap       <= '{hr: HR_W_MAX'(w_hr_nxt), min: w_min_nxt, s: w_s_nxt, ms: w_ms_nxt};
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_ms    = r_lap.ms;
  assign lap_s     = r_lap.s;
  assign lap_min   = r_lap.min;
  assign lap_hr    = HR_BITS'(r_lap.hr);
  assign lap_valid = r_lap_valid;
`endif

endmodule
